// File: rtl/trace_frame_scheduler.sv
// trace_frame_scheduler: arbitrates GRF and DM write-back events and serialises
// each granted event into one ASCII trace frame, one character per handshake.
//   "^<time>@<pc>: $<reg> <= <data>#"  or  "^<time>@<pc>: *<addr> <= <data>#"
module trace_frame_scheduler #(
    parameter int COLON_SP = 1,
    parameter int ARROW_SP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        grf_req,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_reg,
    input  logic [31:0] grf_data,
    output logic        grf_ack,
    input  logic        dm_req,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data,
    output logic        dm_ack,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, CARET, TIME, AT, PC, COLON, CSP, SIGIL,
        FIELD, ASP, LT, EQ, ESP, DATA, HASH
    } state_t;

    // Index of the last space in each space run; unused when the run length is 0.
    localparam logic [2:0] CSP_LAST = 3'(COLON_SP - 1);
    localparam logic [2:0] ASP_LAST = 3'(ARROW_SP - 1);

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [15:0] time_bcd, lat_time;
    logic [31:0] lat_pc, lat_field, lat_data;
    logic        lat_dm, rr_dm;
    logic        fire, capture, win_dm;
    logic [2:0]  t_last;
    logic [4:0]  reg_val;
    logic [3:0]  reg_tens, reg_ones;
    logic        reg_two;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] p);
        return v[{p, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        logic        c;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign busy       = (state != IDLE);
    assign char_valid = busy;
    assign fire       = char_valid & char_ready;
    assign capture    = (state == IDLE) & (grf_req | dm_req);
    // Contended grant goes to the pointer side; otherwise the lone requester wins.
    assign win_dm     = (grf_req & dm_req) ? rr_dm : dm_req;

    // Field decode: leading-zero-suppressed time width and two-digit register split.
    always_comb begin
        if (lat_time[15:12] != 4'd0)    t_last = 3'd3;
        else if (lat_time[11:8] != 4'd0) t_last = 3'd2;
        else if (lat_time[7:4] != 4'd0)  t_last = 3'd1;
        else                             t_last = 3'd0;
        reg_val = lat_field[4:0];
        if (reg_val >= 5'd30) begin
            reg_tens = 4'd3; reg_ones = 4'(reg_val - 5'd30);
        end else if (reg_val >= 5'd20) begin
            reg_tens = 4'd2; reg_ones = 4'(reg_val - 5'd20);
        end else if (reg_val >= 5'd10) begin
            reg_tens = 4'd1; reg_ones = 4'(reg_val - 5'd10);
        end else begin
            reg_tens = 4'd0; reg_ones = reg_val[3:0];
        end
        reg_two = (reg_val >= 5'd10);
    end

    // Character sequencing: emit the current character, advance on each accepted transfer.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        char_out = 8'h00;
        case (state)
            IDLE:  if (capture) state_nx = CARET;
            CARET: begin char_out = 8'h5e; if (fire) state_nx = TIME; end
            TIME: begin
                char_out = hex_char(nib({16'h0, lat_time}, t_last - idx));
                if (fire) begin
                    if (idx == t_last) state_nx = AT;
                    else               idx_nx = idx + 3'd1;
                end
            end
            AT:    begin char_out = 8'h40; if (fire) state_nx = PC; end
            PC: begin
                char_out = hex_char(nib(lat_pc, 3'd7 - idx));
                if (fire) begin
                    if (idx == 3'd7) state_nx = COLON;
                    else             idx_nx = idx + 3'd1;
                end
            end
            COLON: begin
                char_out = 8'h3a;
                if (fire) state_nx = (COLON_SP > 0) ? CSP : SIGIL;
            end
            CSP: begin
                char_out = 8'h20;
                if (fire) begin
                    if (idx == CSP_LAST) state_nx = SIGIL;
                    else                 idx_nx = idx + 3'd1;
                end
            end
            SIGIL: begin
                char_out = lat_dm ? 8'h2a : 8'h24;
                if (fire) state_nx = FIELD;
            end
            FIELD: begin
                if (lat_dm) char_out = hex_char(nib(lat_field, 3'd7 - idx));
                else        char_out = hex_char((reg_two && idx == 3'd0) ? reg_tens : reg_ones);
                if (fire) begin
                    if (lat_dm ? (idx == 3'd7) : (idx == {2'b00, reg_two}))
                        state_nx = (ARROW_SP > 0) ? ASP : LT;
                    else
                        idx_nx = idx + 3'd1;
                end
            end
            ASP: begin
                char_out = 8'h20;
                if (fire) begin
                    if (idx == ASP_LAST) state_nx = LT;
                    else                 idx_nx = idx + 3'd1;
                end
            end
            LT:    begin char_out = 8'h3c; if (fire) state_nx = EQ; end
            EQ:    begin char_out = 8'h3d; if (fire) state_nx = ESP; end
            ESP:   begin char_out = 8'h20; if (fire) state_nx = DATA; end
            DATA: begin
                char_out = hex_char(nib(lat_data, 3'd7 - idx));
                if (fire) begin
                    if (idx == 3'd7) state_nx = HASH;
                    else             idx_nx = idx + 3'd1;
                end
            end
            HASH:  begin char_out = 8'h23; if (fire) state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
        // Digit index restarts whenever a new state is entered.
        if (state_nx != state) idx_nx = 3'd0;
    end

    // State register; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Timestamp, round-robin pointer, event capture and ack pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_bcd  <= 16'h0000;
            rr_dm     <= 1'b0;
            grf_ack   <= 1'b0;
            dm_ack    <= 1'b0;
            lat_time  <= 16'h0000;
            lat_pc    <= 32'h0;
            lat_field <= 32'h0;
            lat_data  <= 32'h0;
            lat_dm    <= 1'b0;
        end else begin
            grf_ack <= capture & ~win_dm;
            dm_ack  <= capture & win_dm;
            if (tick) time_bcd <= bcd_inc(time_bcd);
            if (capture) begin
                lat_time  <= time_bcd;
                lat_dm    <= win_dm;
                lat_pc    <= win_dm ? dm_pc : grf_pc;
                lat_field <= win_dm ? dm_addr : {27'h0, grf_reg};
                lat_data  <= win_dm ? dm_data : grf_data;
                rr_dm     <= ~win_dm;
            end
        end
    end

endmodule

// File: tb/tb_trace_frame_scheduler.sv
// Bench for trace_frame_scheduler: directed scenarios plus randomized events,
// expected frames built from a string-level model of the trace format.
module tb_trace_frame_scheduler;

    logic        clk = 0;
    logic        reset = 1, tick = 0;
    logic        grf_req = 0, dm_req = 0, grf_req6 = 0, dm_req6 = 0;
    logic [31:0] grf_pc = 0, grf_data = 0, dm_pc = 0, dm_addr = 0, dm_data = 0;
    logic [4:0]  grf_reg = 0;
    logic        char_ready = 1;
    logic        grf_ack, dm_ack, char_valid, busy;
    logic [7:0]  char_out;
    logic        grf_ack6, dm_ack6, char_valid6, busy6;
    logic [7:0]  char_out6;

    int checks = 0, errors = 0;
    int m_tm = 0;
    bit m_rr = 0, g_p = 0, d_p = 0;

    always #5 clk = ~clk;

    trace_frame_scheduler u_dut (
        .clk(clk), .reset(reset), .tick(tick),
        .grf_req(grf_req), .grf_pc(grf_pc), .grf_reg(grf_reg), .grf_data(grf_data), .grf_ack(grf_ack),
        .dm_req(dm_req), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ack(dm_ack),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready), .busy(busy)
    );

    trace_frame_scheduler #(.COLON_SP(0), .ARROW_SP(2)) u_dut6 (
        .clk(clk), .reset(reset), .tick(tick),
        .grf_req(grf_req6), .grf_pc(grf_pc), .grf_reg(grf_reg), .grf_data(grf_data), .grf_ack(grf_ack6),
        .dm_req(dm_req6), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ack(dm_ack6),
        .char_out(char_out6), .char_valid(char_valid6), .char_ready(char_ready), .busy(busy6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
        end
    endtask

    function automatic string exp_frame(input bit is_dm, input int t, input logic [31:0] pc,
                                        input logic [31:0] f, input logic [31:0] d,
                                        input int csp, input int asp);
        string s;
        s = $sformatf("^%0d@%08h:", t, pc);
        for (int i = 0; i < csp; i++) s = {s, " "};
        if (is_dm) s = {s, $sformatf("*%08h", f)};
        else       s = {s, $sformatf("$%0d", f[4:0])};
        for (int i = 0; i < asp; i++) s = {s, " "};
        s = {s, $sformatf("<= %08h#", d)};
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1; tick = 0; grf_req = 0; dm_req = 0; grf_req6 = 0; char_ready = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        m_tm = 0; m_rr = 0; g_p = 0; d_p = 0;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1;
        end
        @(negedge clk);
        tick = 0;
        m_tm = (m_tm + n) % 10000;
    endtask

    // Collects one frame from the selected instance; checks stall stability and busy.
    task automatic collect(input bit sel, input bit rnd, output string s, output int gaps,
                           output int span, output int gacks, output int dacks);
        bit done = 0, started = 0, prev_stall = 0, r;
        logic v, bz, ga, da;
        logic [7:0] ch, pch = 8'h00;
        s = ""; gaps = 0; span = 0; gacks = 0; dacks = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            tick = 0;
            v  = sel ? char_valid6 : char_valid;
            ch = sel ? char_out6 : char_out;
            bz = sel ? busy6 : busy;
            ga = sel ? grf_ack6 : grf_ack;
            da = sel ? dm_ack6 : dm_ack;
            if (ga) begin gacks++; if (sel) grf_req6 = 0; else grf_req = 0; end
            if (da) begin dacks++; dm_req = 0; end
            if (prev_stall) begin
                chk("stall_valid", v, 1);
                chk("stall_char", ch, pch);
            end
            if (v) started = 1;
            else if (started) gaps++;
            if (started) span++;
            chk("busy", bz, started);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            char_ready = r;
            if (v && r) begin
                s = $sformatf("%s%c", s, ch);
                if (ch == 8'h23) done = 1;
            end
            prev_stall = v && !r;
            pch = ch;
        end
        chk("frame_done", done, 1);
        char_ready = 1;
    endtask

    // Model picks the winner, builds the expected frame and updates pointer/pending.
    task automatic run_frame(input bit rnd, input string tag);
        string e, s;
        int gaps, span, ga, da;
        bit w_dm;
        w_dm = (g_p && d_p) ? m_rr : d_p;
        if (w_dm) e = exp_frame(1, m_tm, dm_pc, dm_addr, dm_data, 1, 1);
        else      e = exp_frame(0, m_tm, grf_pc, {27'h0, grf_reg}, grf_data, 1, 1);
        collect(0, rnd, s, gaps, span, ga, da);
        chk_str(tag, s, e);
        chk({tag, "_gaps"}, gaps, 0);
        if (!rnd) chk({tag, "_span"}, span, e.len());
        chk({tag, "_grf_ack"}, ga, w_dm ? 0 : 1);
        chk({tag, "_dm_ack"}, da, w_dm ? 1 : 0);
        if (w_dm) d_p = 0; else g_p = 0;
        m_rr = !w_dm;
    endtask

    initial begin
        string s;
        int gaps, span, ga, da, n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", char_valid, 0);
        chk("rst_char", char_out, 8'h00);
        chk("rst_grf_ack", grf_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy6", busy6, 0);
        reset = 0;

        // T1: fixed GRF frame, ready held high
        do_reset();
        do_ticks(12);
        grf_pc = 32'h00003000; grf_reg = 5'd5; grf_data = 32'h0000abcd;
        grf_req = 1; g_p = 1;
        run_frame(0, "t1");

        // T2: contention, GRF then DM, then GRF again
        do_reset();
        dm_pc = 32'h00003004; dm_addr = 32'h00000010; dm_data = 32'hffffffff;
        grf_req = 1; dm_req = 1; g_p = 1; d_p = 1;
        run_frame(0, "t2_first");
        run_frame(0, "t2_second");
        grf_req = 1; dm_req = 1; g_p = 1; d_p = 1;
        run_frame(0, "t2_third");
        run_frame(0, "t2_fourth");

        // T3: T1 under random backpressure
        do_reset();
        do_ticks(12);
        grf_pc = 32'h00003000; grf_reg = 5'd5; grf_data = 32'h0000abcd;
        grf_req = 1; g_p = 1;
        run_frame(1, "t3");

        // T4: timestamp wrap, then tick on the capture edge
        do_reset();
        do_ticks(10000);
        grf_reg = 5'd31; grf_data = 32'h0;
        grf_req = 1; g_p = 1;
        run_frame(0, "t4_wrap");
        do_reset();
        do_ticks(7);
        tick = 1; grf_req = 1; g_p = 1;
        run_frame(0, "t4_tick_cap");
        m_tm = (m_tm + 1) % 10000;
        grf_reg = 5'd10; grf_req = 1; g_p = 1;
        run_frame(0, "t4_after");

        // T5: reset mid-frame with request held
        do_reset();
        do_ticks(3);
        grf_pc = 32'h00001234; grf_reg = 5'd9; grf_data = 32'h00000055;
        grf_req = 1; g_p = 1;
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge clk);
            char_ready = 1;
            if (char_valid) n++;
        end
        chk("t5_prefix", n, 5);
        reset = 1;
        @(negedge clk);
        chk("t5_valid", char_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ack", grf_ack, 0);
        chk("t5_char", char_out, 8'h00);
        reset = 0;
        m_tm = 0; m_rr = 0;
        run_frame(0, "t5_restart");

        // Randomized events
        for (int k = 0; k < 8; k++) begin
            int kind;
            do_ticks($urandom_range(0, 40));
            kind = $urandom_range(0, 2);
            if (kind != 1) begin
                grf_pc = $urandom; grf_reg = 5'($urandom_range(0, 31)); grf_data = $urandom;
                grf_req = 1; g_p = 1;
            end
            if (kind != 0) begin
                dm_pc = $urandom; dm_addr = $urandom; dm_data = $urandom;
                dm_req = 1; d_p = 1;
            end
            for (int f = 0; f < 2 && (g_p || d_p); f++) run_frame(1, $sformatf("rnd%0d_%0d", k, f));
        end

        // T6: COLON_SP=0, ARROW_SP=2 instance
        do_reset();
        do_ticks(3);
        grf_pc = 32'h0; grf_reg = 5'd0; grf_data = 32'h1;
        grf_req6 = 1;
        collect(1, 0, s, gaps, span, ga, da);
        chk_str("t6", s, exp_frame(0, 3, 32'h0, 32'h0, 32'h1, 0, 2));
        chk("t6_span", span, 28);
        chk("t6_ack", ga, 1);
        @(negedge clk);
        chk("t6_busy_end", busy6, 0);
        chk("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
